// File: rtl/sram_arbiter.sv
// Arbitrates one 16-bit single-port SRAM between fetch (read-only) and memory stage (load/store).
// Each 32-bit access runs two half-word phases of WAIT_CYCLES+1 cycles; the memory stage has fixed priority.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [31:0]        if_addr,
  output logic [31:0]        if_rdata,
  output logic               if_ready,
  input  logic               mem_rd_en,
  input  logic               mem_wr_en,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  output logic [31:0]        mem_rdata,
  output logic               mem_ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES);

  state_t             state, state_nxt;
  logic [3:0]         cnt;
  logic               own_mem;
  logic               is_wr;
  logic [SRAM_AW-2:0] word_q;
  logic [31:0]        wdata_q;
  logic [15:0]        lo_q;
  logic               phase_end;
  logic               mem_any;
  logic               unused_addr_bits;

  assign phase_end = (cnt == LAST);
  assign mem_any   = mem_rd_en | mem_wr_en;

  // Byte-lane bits and bits above the SRAM window are dropped on purpose.
  assign unused_addr_bits = ^{if_addr[31:SRAM_AW+1], if_addr[1:0],
                              mem_addr[31:SRAM_AW+1], mem_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_any || if_req) state_nxt = LO;
      LO:      if (phase_end) state_nxt = HI;
      HI:      if (phase_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt       <= '0;
      own_mem   <= 1'b0;
      is_wr     <= 1'b0;
      word_q    <= '0;
      wdata_q   <= '0;
      lo_q      <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      if (state == LO || state == HI) cnt <= phase_end ? 4'd0 : cnt + 4'd1;
      else                            cnt <= '0;

      if (state == IDLE) begin
        if (mem_any) begin
          own_mem <= 1'b1;
          is_wr   <= mem_wr_en;
          word_q  <= mem_addr[SRAM_AW:2];
          wdata_q <= mem_wdata;
        end else if (if_req) begin
          own_mem <= 1'b0;
          is_wr   <= 1'b0;
          word_q  <= if_addr[SRAM_AW:2];
        end
      end

      if (state == LO && phase_end && !is_wr) lo_q <= sram_dq_in;
      // Assemble the word at the end of HI so it is visible together with ready.
      if (state == HI && phase_end && !is_wr) begin
        if (own_mem) mem_rdata <= {sram_dq_in, lo_q};
        else         if_rdata  <= {sram_dq_in, lo_q};
      end
    end
  end

  always_comb begin
    if_ready    = 1'b0;
    mem_ready   = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    case (state)
      LO, HI: begin
        sram_addr = {word_q, (state == HI)};
        if (is_wr) begin
          sram_dq_oe  = 1'b1;
          sram_dq_out = (state == HI) ? wdata_q[31:16] : wdata_q[15:0];
          // Last phase cycle releases we_n while data and address are still driven.
          sram_we_n   = phase_end;
        end else begin
          sram_oe_n = 1'b0;
        end
      end
      DONE: begin
        if (own_mem) mem_ready = 1'b1;
        else         if_ready  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized traffic against a word-level memory model.
`timescale 1ns/1ps
module tb_sram_arbiter;
  localparam int AW = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: WAIT_CYCLES=1
  logic          rst, if_req, if_ready, mem_rd_en, mem_wr_en, mem_ready;
  logic [31:0]   if_addr, if_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out;
  logic [15:0]   sram_dq_in = '0;
  logic          sram_dq_oe, sram_we_n, sram_oe_n;

  // DUT B: WAIT_CYCLES=3
  logic          rst_b, if_req_b, if_ready_b, mem_rd_en_b, mem_wr_en_b, mem_ready_b;
  logic [31:0]   if_addr_b, if_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic [AW-1:0] sram_addr_b;
  logic [15:0]   sram_dq_out_b;
  logic [15:0]   sram_dq_in_b = '0;
  logic          sram_dq_oe_b, sram_we_n_b, sram_oe_n_b;

  sram_arbiter #(.WAIT_CYCLES(1), .SRAM_AW(AW)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ready(if_ready), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n));

  sram_arbiter #(.WAIT_CYCLES(3), .SRAM_AW(AW)) dut_b (
    .clk(clk), .rst(rst_b), .if_req(if_req_b), .if_addr(if_addr_b), .if_rdata(if_rdata_b),
    .if_ready(if_ready_b), .mem_rd_en(mem_rd_en_b), .mem_wr_en(mem_wr_en_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .mem_ready(mem_ready_b), .sram_addr(sram_addr_b),
    .sram_dq_out(sram_dq_out_b), .sram_dq_in(sram_dq_in_b), .sram_dq_oe(sram_dq_oe_b),
    .sram_we_n(sram_we_n_b), .sram_oe_n(sram_oe_n_b));

  int checks = 0;
  int failures = 0;
  int viol = 0;
  int wrong_ready = 0;

  bit [15:0] smem [0:(1<<AW)-1];
  bit [31:0] ref_mem [int];

  logic [AW-1:0] tr_addr [0:63];
  logic [15:0]   tr_dq   [0:63];
  logic          tr_we   [0:63];
  logic          tr_dqoe [0:63];

  // Pad-level SRAM for DUT A; DUT B reads an address-derived pattern.
  always @(negedge clk) begin
    if (!sram_we_n) smem[sram_addr] = sram_dq_out;
    sram_dq_in   = smem[sram_addr];
    sram_dq_in_b = sram_addr_b[15:0] ^ 16'h5A5A;
    if ((if_ready && mem_ready) || (!sram_we_n && !sram_oe_n) || (sram_dq_oe && !sram_oe_n))
      viol++;
    if ((if_ready_b && mem_ready_b) || (!sram_we_n_b && !sram_oe_n_b) || (sram_dq_oe_b && !sram_oe_n_b))
      viol++;
  end

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % (32'd1 << (AW - 1)));
  endfunction

  function automatic bit [31:0] ref_rd(input int i);
    if (ref_mem.exists(i)) return ref_mem[i];
    return 32'd0;
  endfunction

  function automatic logic [15:0] pat_b(input int half_addr);
    logic [31:0] h;
    h = half_addr;
    return h[15:0] ^ 16'h5A5A;
  endfunction

  task automatic preload(input int i, input bit [31:0] d);
    smem[2*i]     = d[15:0];
    smem[2*i + 1] = d[31:16];
    ref_mem[i]    = d;
  endtask

  // Drives one access on DUT A from a negedge and waits for its ready; lat=-1 on timeout.
  task automatic run_access(input bit is_if, input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, output int lat, output logic [31:0] rdata);
    @(negedge clk);
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      mem_rd_en = rd; mem_wr_en = wr; mem_addr = addr; mem_wdata = wdata;
    end
    lat = -1;
    rdata = '0;
    for (int c = 1; c < 60; c++) begin
      @(negedge clk);
      tr_addr[c] = sram_addr; tr_dq[c] = sram_dq_out; tr_we[c] = sram_we_n; tr_dqoe[c] = sram_dq_oe;
      if (is_if ? mem_ready : if_ready) wrong_ready++;
      if (is_if ? if_ready : mem_ready) begin
        lat = c;
        rdata = is_if ? if_rdata : mem_rdata;
        break;
      end
    end
    if_req = 1'b0; mem_rd_en = 1'b0; mem_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; rst_b = 1'b0;
    if_req = 0; if_addr = 0; mem_rd_en = 0; mem_wr_en = 0; mem_addr = 0; mem_wdata = 0;
    if_req_b = 0; if_addr_b = 0; mem_rd_en_b = 0; mem_wr_en_b = 0; mem_addr_b = 0; mem_wdata_b = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1; rst_b = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({if_ready, mem_ready, sram_we_n, sram_oe_n, sram_dq_oe} !== 5'b00110) begin
        failures++;
        $display("FAIL reset_ctrl cycle %0d: rdy/we_n/oe_n/dq_oe=%b expected 00110", c,
                 {if_ready, mem_ready, sram_we_n, sram_oe_n, sram_dq_oe});
      end
      checks++;
      if ({if_rdata, mem_rdata, sram_dq_out} !== 80'd0 || sram_addr !== '0) begin
        failures++;
        $display("FAIL reset_data cycle %0d: if_rdata=%h mem_rdata=%h dq_out=%h addr=%h expected all 0",
                 c, if_rdata, mem_rdata, sram_dq_out, sram_addr);
      end
      checks++;
      if ({if_ready_b, mem_ready_b, sram_we_n_b, sram_oe_n_b, sram_dq_oe_b} !== 5'b00110
          || if_rdata_b !== 32'd0 || mem_rdata_b !== 32'd0) begin
        failures++;
        $display("FAIL reset_b cycle %0d: ctrl=%b if_rdata=%h mem_rdata=%h expected 00110/0/0", c,
                 {if_ready_b, mem_ready_b, sram_we_n_b, sram_oe_n_b, sram_dq_oe_b}, if_rdata_b, mem_rdata_b);
      end
    end
  endtask

  task automatic test_store();
    int lat; logic [31:0] rd; int we_lo, we_hi;
    run_access(0, 0, 1, 32'd1024, 32'h0000060A, lat, rd);
    ref_mem[widx(32'd1024)] = 32'h0000060A;
    checks++;
    if (lat !== 5) begin failures++; $display("FAIL store_latency: got %0d expected 5", lat); end
    checks++;
    if (tr_addr[1] !== 18'd512 || tr_dq[1] !== 16'h060A || tr_dqoe[1] !== 1'b1) begin
      failures++;
      $display("FAIL store_lo: addr=%0d dq=%h dq_oe=%b expected 512 060a 1", tr_addr[1], tr_dq[1], tr_dqoe[1]);
    end
    checks++;
    if (tr_addr[3] !== 18'd513 || tr_dq[3] !== 16'h0000 || tr_dqoe[4] !== 1'b1) begin
      failures++;
      $display("FAIL store_hi: addr=%0d dq=%h dq_oe=%b expected 513 0000 1", tr_addr[3], tr_dq[3], tr_dqoe[4]);
    end
    we_lo = 0; we_hi = 0;
    for (int c = 1; c <= 2; c++) if (!tr_we[c]) we_lo++;
    for (int c = 3; c <= 4; c++) if (!tr_we[c]) we_hi++;
    checks++;
    if (we_lo != 1 || we_hi != 1 || tr_we[2] !== 1'b1 || tr_we[4] !== 1'b1) begin
      failures++;
      $display("FAIL store_we_width: lo=%0d hi=%0d (hold lo=%b hi=%b) expected 1 1 (1 1)",
               we_lo, we_hi, tr_we[2], tr_we[4]);
    end
    checks++;
    if (rd !== 32'd0) begin failures++; $display("FAIL store_rdata_kept: mem_rdata=%h expected 0", rd); end
    @(negedge clk);
    checks++;
    if (mem_ready !== 1'b0) begin failures++; $display("FAIL store_ready_pulse: mem_ready=%b expected 0", mem_ready); end
  endtask

  task automatic test_load();
    int lat; logic [31:0] rd;
    run_access(0, 1, 0, 32'd1024, 32'hDEADBEEF, lat, rd);
    checks++;
    if (lat !== 5 || rd !== 32'h0000060A) begin
      failures++;
      $display("FAIL load: latency=%0d data=%h expected 5 0000060a", lat, rd);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (mem_rdata !== 32'h0000060A) begin
      failures++; $display("FAIL load_hold: mem_rdata=%h expected 0000060a", mem_rdata);
    end
  endtask

  task automatic test_if_read();
    int lat; logic [31:0] rd;
    preload(1, 32'h80011234);
    run_access(1, 1, 0, 32'h4, 32'd0, lat, rd);
    checks++;
    if (lat !== 5 || rd !== 32'h80011234) begin
      failures++;
      $display("FAIL if_read: latency=%0d data=%h expected 5 80011234", lat, rd);
    end
    checks++;
    if (mem_rdata !== 32'h0000060A) begin
      failures++; $display("FAIL if_read_mem_hold: mem_rdata=%h expected 0000060a", mem_rdata);
    end
  endtask

  task automatic test_contention();
    int mcyc, icyc, both; logic [31:0] md, id, iw;
    iw = $urandom();
    preload(3, iw);
    mcyc = -1; icyc = -1; both = 0; md = 'x; id = 'x;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'd12; mem_rd_en = 1'b1; mem_addr = 32'd1024;
    for (int c = 1; c < 40; c++) begin
      @(negedge clk);
      if (if_ready && mem_ready) both++;
      if (mem_ready) begin mcyc = c; md = mem_rdata; mem_rd_en = 1'b0; end
      if (if_ready)  begin icyc = c; id = if_rdata;  if_req = 1'b0; end
      if (mcyc >= 0 && icyc >= 0) break;
    end
    if_req = 1'b0; mem_rd_en = 1'b0;
    checks++;
    if (mcyc !== 5 || md !== 32'h0000060A) begin
      failures++; $display("FAIL contention_mem: cycle=%0d data=%h expected 5 0000060a", mcyc, md);
    end
    checks++;
    if (icyc !== 11 || id !== iw) begin
      failures++; $display("FAIL contention_if: cycle=%0d data=%h expected 11 %h", icyc, id, iw);
    end
    checks++;
    if (both !== 0) begin failures++; $display("FAIL contention_both_ready: %0d cycles expected 0", both); end
  endtask

  task automatic test_reset_mid();
    int rdy;
    @(negedge clk);
    mem_wr_en_b = 1'b1; mem_addr_b = 32'd2048; mem_wdata_b = $urandom();
    repeat (6) @(negedge clk);
    checks++;
    if (sram_addr_b !== 18'd1025 || sram_dq_oe_b !== 1'b1) begin
      failures++; $display("FAIL midreset_in_hi: addr=%0d dq_oe=%b expected 1025 1", sram_addr_b, sram_dq_oe_b);
    end
    rst_b = 1'b0; mem_wr_en_b = 1'b0;
    @(negedge clk);
    checks++;
    if ({sram_we_n_b, sram_oe_n_b, sram_dq_oe_b, if_ready_b, mem_ready_b} !== 5'b11000 || sram_addr_b !== '0) begin
      failures++;
      $display("FAIL midreset_idle: we_n/oe_n/dq_oe/rdy=%b addr=%0d expected 11000 0",
               {sram_we_n_b, sram_oe_n_b, sram_dq_oe_b, if_ready_b, mem_ready_b}, sram_addr_b);
    end
    rst_b = 1'b1;
    rdy = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (if_ready_b || mem_ready_b) rdy++;
    end
    checks++;
    if (rdy !== 0) begin failures++; $display("FAIL midreset_no_ready: %0d pulses expected 0", rdy); end
  endtask

  task automatic test_wait3();
    int lat; logic [31:0] a, rd, exp_d; int h;
    a = $urandom();
    h = 2 * widx(a);
    exp_d = {pat_b(h + 1), pat_b(h)};
    @(negedge clk);
    mem_rd_en_b = 1'b1; mem_addr_b = a;
    lat = -1; rd = '0;
    for (int c = 1; c < 40; c++) begin
      @(negedge clk);
      if (mem_ready_b) begin lat = c; rd = mem_rdata_b; break; end
    end
    mem_rd_en_b = 1'b0;
    checks++;
    if (lat !== 9 || rd !== exp_d) begin
      failures++; $display("FAIL wait3_read: latency=%0d data=%h expected 9 %h", lat, rd, exp_d);
    end
  endtask

  task automatic test_random();
    int lat, op, i; logic [31:0] a, wd, rd, exp_if, exp_mem;
    exp_if = if_rdata_model_init();
    exp_mem = 32'h0000060A;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 3);
      a  = ($urandom() & 32'hFFF8_0000) | ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
      wd = $urandom();
      i  = widx(a);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      case (op)
        0: run_access(1, 1, 0, a, 32'd0, lat, rd);
        1: run_access(0, 1, 0, a, wd, lat, rd);
        2: run_access(0, 0, 1, a, wd, lat, rd);
        default: run_access(0, 1, 1, a, wd, lat, rd);
      endcase
      checks++;
      if (lat !== 5) begin failures++; $display("FAIL rand_latency op=%0d n=%0d: got %0d expected 5", op, n, lat); end
      if (op >= 2) begin
        ref_mem[i] = wd;
        checks++;
        if (mem_rdata !== exp_mem) begin
          failures++; $display("FAIL rand_write_keeps_rdata n=%0d: mem_rdata=%h expected %h", n, mem_rdata, exp_mem);
        end
      end else begin
        if (op == 0) exp_if = ref_rd(i); else exp_mem = ref_rd(i);
        checks++;
        if (rd !== ref_rd(i)) begin
          failures++; $display("FAIL rand_read op=%0d n=%0d addr=%h: data=%h expected %h", op, n, a, rd, ref_rd(i));
        end
      end
      checks++;
      if (if_rdata !== exp_if || mem_rdata !== exp_mem) begin
        failures++;
        $display("FAIL rand_hold n=%0d: if_rdata=%h mem_rdata=%h expected %h %h", n, if_rdata, mem_rdata, exp_if, exp_mem);
      end
    end
  endtask

  function automatic logic [31:0] if_rdata_model_init();
    return ref_rd(3);
  endfunction

  task automatic test_bus_safety();
    checks++;
    if (viol !== 0 || wrong_ready !== 0) begin
      failures++; $display("FAIL bus_safety: violations=%0d wrong_ready=%0d expected 0 0", viol, wrong_ready);
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_if_read();
    test_contention();
    test_reset_mid();
    test_wait3();
    test_random();
    test_bus_safety();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
